cam_pixel_capture: RTL
======================

// Module: cam_pixel_capture
// PURPOSE
//  Front-end capture stage for the OV7670 camera, in the pclk domain.
//  - Frame-locks on cam_vsync and pairs cam_data bytes into RGB565 pixels.
//  - Tags each pixel with x/y coordinates and start-of-frame/end-of-line flags.
//  - Presents pixels on a valid/ready stream to downstream buffering and VGA output.
//  - Camera cannot stall: pixels not accepted downstream are dropped and counted.
// PARAMETERS
//  H_PIXELS   640  pixels per valid line
//  V_LINES    480  valid lines per frame
//  X_W        10   width of pix_x
//  Y_W        9    width of pix_y
//  SWAP_BYTES 0    0: first byte = pix_data[15:8]; 1: first byte = pix_data[7:0]
// PORTS
//  pclk        in   1     pixel clock from camera, rising edge
//  reset       in   1     asynchronous, active-high
//  cam_vsync   in   1     high = vertical blanking
//  cam_href    in   1     high = byte valid within line
//  cam_data    in   8     camera byte
//  pix_ready   in   1     downstream accepts pixel
//  pix_valid   out  1     output register holds a pixel
//  pix_data    out  16    RGB565
//  pix_x       out  X_W   column of pix_data
//  pix_y       out  Y_W   row of pix_data
//  pix_sof     out  1     pixel is (0,0)
//  pix_eol     out  1     pixel is column H_PIXELS-1
//  frame_done  out  1     1-cycle pulse at end of a locked frame
//  line_err    out  1     sticky; cleared only by reset
//  ovf_count   out  16    saturating count of dropped pixels
// BEHAVIOUR
//  Reset values: all outputs 0; FSM in S_SYNC; all internal counters 0.
//  Reset mid-frame:
//   - In-flight pixel is discarded.
//   - Capture resumes only at the next full vsync high->low sequence.
//  FSM states:
//   - S_SYNC: wait for cam_vsync=1 -> S_VBLANK.
//   - S_VBLANK: wait for cam_vsync=0 -> S_LINE; clear x and y.
//   - S_LINE: on href=1, sample byte0 -> S_LO.
//   - S_HI: on href=1, sample byte0 -> S_LO.
//   - S_HI: on href=0, end of line -> S_LINE.
//   - S_LO: on href=1, sample byte1 and emit pixel -> S_HI.
//   - S_LO: on href=0 (odd byte count in line), set line_err -> S_LINE.
//  End of line:
//   - Increment y.
//   - Clear x.
//   - If bytes/2 != H_PIXELS, set line_err.
//  cam_vsync=1 while in S_LINE, S_HI or S_LO:
//   - Pulse frame_done for 1 cycle.
//   - If y != V_LINES, set line_err.
//   - Go to S_VBLANK. An open half-pixel is discarded.
//  Emit timing:
//   - The edge that samples byte1 loads the output register.
//   - pix_valid=1 from that edge; latency is 0 cycles after byte1.
//   - pix_x and pix_y are the pre-increment counter values.
//  Pixels with x>=H_PIXELS or y>=V_LINES:
//   - Not emitted.
//   - Set line_err.
//   - Do not increment ovf_count.
//  Handshake:
//   - Transfer occurs on an edge where pix_valid && pix_ready.
//   - pix_* fields are held stable while pix_valid && !pix_ready.
//   - pix_valid drops after a transfer unless a new pixel loads on the same edge.
//  Simultaneous transfer and new pixel: the new pixel is loaded and pix_valid stays 1.
//  New pixel while pix_valid && !pix_ready:
//   - New pixel is dropped; the held pixel is kept.
//   - ovf_count increments and saturates at 16'hFFFF.
//  Internal x/y counters:
//   - x is X_W+1 bits wide; y is Y_W+1 bits wide.
//   - Both saturate at their all-ones value and do not wrap.
// CONFIGURATION
//  CAM_CAPTURE_STATS_EN defined:
//   - Adds output stat_line_len [X_W:0]: pixel count of the last line, latched at line end.
//   - Adds output stat_lines [Y_W:0]: line count of the last frame, latched on frame_done.
//   - Both reset to 0.
//  CAM_CAPTURE_STATS_EN undefined: these ports and their registers are absent; all other behaviour is identical.
// TESTING
//  T1: 2x2 frame (H_PIXELS=2, V_LINES=2), bytes 11,22,33,44 / 55,66,77,88, pix_ready=1
//      -> pixels 1122(0,0,sof), 3344(1,0,eol), 5566(0,1), 7788(1,1,eol); frame_done once; line_err=0.
//  T2: pix_ready=0 for a whole 4-pixel line -> first pixel held, pix_valid=1 throughout, ovf_count=3.
//  T3: pix_ready pulses on the same edge as byte1 of the next pixel -> no drop, pix_valid stays 1, ovf_count unchanged.
//  T4: line of 3 bytes -> line_err=1; next line still captures correctly from x=0.
//  T5: reset asserted mid-line -> outputs 0 immediately; data before the next vsync high->low is ignored.
//  T6: SWAP_BYTES=1 with bytes AB,CD -> pix_data=16'hCDAB.
//      With CAM_CAPTURE_STATS_EN and the T1 frame -> stat_line_len=2, stat_lines=2.

Source files
------------

// File: rtl/cam_pixel_capture.sv
// cam_pixel_capture: OV7670 byte-pair to RGB565 capture with x/y tagging and a non-stalling valid/ready output.
// Optional CAM_CAPTURE_STATS_EN adds stat_line_len/stat_lines observability registers.
module cam_pixel_capture #(
  parameter int H_PIXELS   = 640,
  parameter int V_LINES    = 480,
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter bit SWAP_BYTES = 1'b0
) (
  input  logic           pclk,
  input  logic           reset,
  input  logic           cam_vsync,
  input  logic           cam_href,
  input  logic [7:0]     cam_data,
  input  logic           pix_ready,
  output logic           pix_valid,
  output logic [15:0]    pix_data,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           pix_sof,
  output logic           pix_eol,
  output logic           frame_done,
  output logic           line_err,
  output logic [15:0]    ovf_count
`ifdef CAM_CAPTURE_STATS_EN
  ,
  output logic [X_W:0]   stat_line_len,
  output logic [Y_W:0]   stat_lines
`endif
);
  typedef enum logic [2:0] {S_SYNC, S_VBLANK, S_LINE, S_HI, S_LO} state_t;
  localparam logic [X_W:0] H_MAX  = (X_W+1)'(H_PIXELS);
  localparam logic [X_W:0] H_LAST = (X_W+1)'(H_PIXELS - 1);
  localparam logic [Y_W:0] V_MAX  = (Y_W+1)'(V_LINES);
  state_t       state, state_n;
  logic [X_W:0] x;
  logic [Y_W:0] y;
  logic [7:0]   byte0;
  logic         in_line, frame_end, line_end, take_b0, take_b1, in_range, load, drop;
  always_comb begin
    in_line   = state == S_LINE || state == S_HI || state == S_LO;
    frame_end = in_line && cam_vsync;
    line_end  = !cam_vsync && !cam_href && (state == S_HI || state == S_LO);
    take_b0   = !cam_vsync && cam_href && (state == S_LINE || state == S_HI);
    take_b1   = !cam_vsync && cam_href && state == S_LO;
    in_range  = x < H_MAX && y < V_MAX;
    load      = take_b1 && in_range && (!pix_valid || pix_ready);
    drop      = take_b1 && in_range && pix_valid && !pix_ready;
    state_n   = frame_end                          ? S_VBLANK :
                take_b0                            ? S_LO     :
                take_b1                            ? S_HI     :
                line_end                           ? S_LINE   :
                (state == S_SYNC && cam_vsync)     ? S_VBLANK :
                (state == S_VBLANK && !cam_vsync)  ? S_LINE   : state;
  end
  always_ff @(posedge pclk or posedge reset)
    if (reset) state <= S_SYNC;
    else       state <= state_n;
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      byte0      <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      ovf_count  <= '0;
    end else begin
      frame_done <= frame_end;
      if (state == S_VBLANK) begin
        x <= '0;
        y <= '0;
      end else if (line_end) begin
        x <= '0;
        y <= &y ? y : y + 1'b1;
      end else if (take_b1) begin
        x <= &x ? x : x + 1'b1;
      end
      if (take_b0) byte0 <= cam_data;
      // odd byte count, short/long line, wrong line count and out-of-window pixels all latch the error
      line_err <= line_err | (line_end && (state == S_LO || x != H_MAX)) |
                  (frame_end && y != V_MAX) | (take_b1 && !in_range);
      if (load) begin
        pix_valid <= 1'b1;
        pix_data  <= SWAP_BYTES ? {cam_data, byte0} : {byte0, cam_data};
        pix_x     <= x[X_W-1:0];
        pix_y     <= y[Y_W-1:0];
        pix_sof   <= x == '0 && y == '0;
        pix_eol   <= x == H_LAST;
      end else if (pix_ready) begin
        pix_valid <= 1'b0;
      end
      if (drop && ~&ovf_count) ovf_count <= ovf_count + 1'b1;
    end
  end
`ifdef CAM_CAPTURE_STATS_EN
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      stat_line_len <= '0;
      stat_lines    <= '0;
    end else begin
      if (line_end)  stat_line_len <= x;
      if (frame_end) stat_lines    <= y;
    end
  end
`endif
endmodule
